// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared constants and helpers for the multi-mode SPI master:
//            FSM state encoding, SPI mode encodings and chip-select width.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SETUP = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;
    localparam logic [1:0] c_ST_HOLD  = 2'd3;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] c_SPI_MODE0 = 2'b00;
    localparam logic [1:0] c_SPI_MODE1 = 2'b01;
    localparam logic [1:0] c_SPI_MODE2 = 2'b10;
    localparam logic [1:0] c_SPI_MODE3 = 2'b11;

    // Width of the chip-select index bus; never narrower than one bit
    function automatic int cs_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_clk_gen
// Purpose  : SCLK half-period timer. Counts the latched divider down and
//            emits a one-cycle strobe on the last cycle of each half-period,
//            plus a flag telling whether the next SHIFT strobe is a leading
//            edge.
// Revision : 1.0 - initial release
// ============================================================================
module spi_clk_gen #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,     // transfer accepted this cycle
    input  logic                 i_en,        // SETUP/SHIFT/HOLD active
    input  logic                 i_shift,     // SHIFT active (edges alternate)
    input  logic [DIV_WIDTH-1:0] i_clk_div,
    output logic                 o_half_tick,
    output logic                 o_lead
);

    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_phase;

    assign o_half_tick = i_en && (r_cnt == '0);
    assign o_lead      = ~r_phase;

    // Down-counter reloads with the latched divider at every half-period end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_start) begin
            r_div   <= i_clk_div;
            r_cnt   <= i_clk_div;
            r_phase <= 1'b0;
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_cnt <= r_div;
                if (i_shift) begin
                    r_phase <= ~r_phase;
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_multi.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_multi
// Purpose  : SPI master, all four CPOL/CPHA modes per transfer, runtime
//            SCLK divider, one-hot active-low chip selects, MSB first,
//            valid/ready request side and one-cycle rx_valid result pulse.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 4,
    parameter int DIV_WIDTH  = 8,
    parameter int CS_SEL_W   = cs_width(NUM_CS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    input  logic [CS_SEL_W-1:0]   i_cs_sel,
    input  logic                  i_cpol,
    input  logic                  i_cpha,
    input  logic [DIV_WIDTH-1:0]  i_clk_div,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_busy,
    output logic                  o_spi_clk,
    output logic                  o_spi_mosi,
    input  logic                  i_spi_miso,
    output logic [NUM_CS-1:0]     o_spi_cs_n
);

    localparam int c_BCNT_W = $clog2(DATA_WIDTH) + 1;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [c_BCNT_W-1:0]   r_bit_cnt;
    logic [NUM_CS-1:0]     r_cs_n;
    logic                  r_cpha;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_ready;
    logic                  r_rx_valid;

    logic                  w_accept;
    logic                  w_tick;
    logic                  w_lead;
    logic                  w_last;
    logic [NUM_CS-1:0]     w_cs_dec;

    assign w_accept   = i_tx_valid && r_ready;
    assign w_last     = (r_bit_cnt == c_BCNT_W'(DATA_WIDTH - 1));

    assign o_tx_ready = r_ready;
    assign o_busy     = ~r_ready;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_spi_clk  = r_sclk;
    assign o_spi_mosi = r_mosi;
    assign o_spi_cs_n = r_cs_n;

    // Out-of-range selects match no line, so every CS stays high
    generate
        for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
            assign w_cs_dec[gi] = (i_cs_sel != CS_SEL_W'(gi));
        end
    endgenerate

    spi_clk_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_accept),
        .i_en        (r_state != c_ST_IDLE),
        .i_shift     (r_state == c_ST_SHIFT),
        .i_clk_div   (i_clk_div),
        .o_half_tick (w_tick),
        .o_lead      (w_lead)
    );

    // Transfer sequencer: accept, setup, 2*DATA_WIDTH SCLK edges, hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_bit_cnt  <= '0;
            r_cs_n     <= '1;
            r_cpha     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_ready    <= 1'b1;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= c_ST_SETUP;
                        r_ready   <= 1'b0;
                        r_cpha    <= i_cpha;
                        r_sclk    <= i_cpol;
                        r_cs_n    <= w_cs_dec;
                        r_bit_cnt <= '0;
                        if (!i_cpha) begin
                            // MSB must be valid before the first (sampling) edge
                            r_mosi <= i_tx_data[DATA_WIDTH-1];
                            r_tx   <= {i_tx_data[DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            r_tx   <= i_tx_data;
                        end
                    end
                end
                c_ST_SETUP: begin
                    if (w_tick) begin
                        r_state <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                        if (w_lead) begin
                            if (!r_cpha) begin
                                r_rx <= {r_rx[DATA_WIDTH-2:0], i_spi_miso};
                            end else begin
                                r_mosi <= r_tx[DATA_WIDTH-1];
                                r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            if (r_cpha) begin
                                r_rx <= {r_rx[DATA_WIDTH-2:0], i_spi_miso};
                            end else if (!w_last) begin
                                // The final trailing edge leaves MOSI untouched
                                r_mosi <= r_tx[DATA_WIDTH-1];
                                r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                            end
                            r_bit_cnt <= r_bit_cnt + c_BCNT_W'(1);
                            if (w_last) begin
                                r_state <= c_ST_HOLD;
                            end
                        end
                    end
                end
                c_ST_HOLD: begin
                    if (w_tick) begin
                        r_state    <= c_ST_IDLE;
                        r_ready    <= 1'b1;
                        r_cs_n     <= '1;
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= r_rx;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_multi
// Purpose  : Directed self-checking bench for spi_master_multi
//            (DATA_WIDTH=8, NUM_CS=5 so that cs_sel=6 is expressible).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [2:0] cs_sel;
    logic       cpol, cpha;
    logic [7:0] clk_div;
    logic [7:0] rx_data;
    logic       rx_valid, busy, spi_clk, spi_mosi, spi_miso;
    logic [4:0] spi_cs_n;

    int n_cmp = 0;
    int n_err = 0;

    // Slave model
    logic       loop_en = 1'b1;
    logic       s_cpol = 1'b0, s_cpha = 1'b0;
    logic [7:0] s_word = 8'h00, s_sh = 8'h00, s_rx = 8'h00;
    logic       s_miso = 1'b0, s_next_lead = 1'b1, p_cs = 1'b0, p_clk = 1'b0;
    wire        cs_act = ~&spi_cs_n;

    assign spi_miso = loop_en ? spi_mosi : s_miso;

    always #5 clk = ~clk;

    spi_master_multi #(
        .DATA_WIDTH (8),
        .NUM_CS     (5),
        .DIV_WIDTH  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_tx_ready (tx_ready),
        .i_cs_sel   (cs_sel),
        .i_cpol     (cpol),
        .i_cpha     (cpha),
        .i_clk_div  (clk_div),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .o_busy     (busy),
        .o_spi_clk  (spi_clk),
        .o_spi_mosi (spi_mosi),
        .i_spi_miso (spi_miso),
        .o_spi_cs_n (spi_cs_n)
    );

    // Slave: loads its word on CS assertion, drives/samples on mode edges
    always @(spi_clk or cs_act) begin
        if (cs_act && !p_cs) begin
            s_sh = s_word; s_rx = 8'h00; s_next_lead = 1'b1;
            if (!s_cpha) begin s_miso = s_sh[7]; s_sh = s_sh << 1; end
        end else if (cs_act && spi_clk != p_clk) begin
            if (s_next_lead && spi_clk != s_cpol) begin
                s_next_lead = 1'b0;
                if (!s_cpha) s_rx = {s_rx[6:0], spi_mosi};
                else begin s_miso = s_sh[7]; s_sh = s_sh << 1; end
            end else if (!s_next_lead && spi_clk == s_cpol) begin
                s_next_lead = 1'b1;
                if (s_cpha) s_rx = {s_rx[6:0], spi_mosi};
                else begin s_miso = s_sh[7]; s_sh = s_sh << 1; end
            end
        end
        p_cs = cs_act; p_clk = spi_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-transfer observations
    int         rv_cyc, cs_first, cs_last, tog, rises, imin, imax;
    logic       other_low;
    logic [7:0] rv_data;
    logic [4:0] rv_cs;
    logic       rv_ready, rv_busy;

    // Called at a negedge with the DUT idle; returns at the rx_valid negedge
    task automatic xfer(input logic [7:0] d, input logic [2:0] cs, input logic pol,
                        input logic pha, input logic [7:0] div);
        int   cyc, last_tog;
        logic prev;
        s_cpol = pol; s_cpha = pha;
        tx_data = d; cs_sel = cs; cpol = pol; cpha = pha; clk_div = div; tx_valid = 1'b1;
        @(negedge clk);
        // scramble request fields: the latched copies must be used
        tx_valid = 1'b0; tx_data = ~d; cpol = ~pol; cpha = ~pha;
        clk_div = div + 8'd2; cs_sel = cs + 3'd1;
        cyc = 1; rv_cyc = -1; cs_first = -1; cs_last = -1; other_low = 1'b0;
        tog = 0; rises = 0; imin = 1000; imax = 0; last_tog = -1; prev = spi_clk;
        rv_data = 8'h00; rv_cs = 5'h00; rv_ready = 1'b0; rv_busy = 1'b1;
        while (rv_cyc < 0 && cyc < 400) begin
            if (rx_valid) begin
                rv_cyc = cyc; rv_data = rx_data; rv_cs = spi_cs_n;
                rv_ready = tx_ready; rv_busy = busy;
            end else begin
                for (int i = 0; i < 5; i++) begin
                    if (!spi_cs_n[i]) begin
                        if (i == int'(cs)) begin
                            if (cs_first < 0) cs_first = cyc;
                            cs_last = cyc;
                        end else other_low = 1'b1;
                    end
                end
                if (cyc > 1 && spi_clk != prev) begin
                    tog++;
                    if (spi_clk) rises++;
                    if (last_tog >= 0) begin
                        if (cyc - last_tog < imin) imin = cyc - last_tog;
                        if (cyc - last_tog > imax) imax = cyc - last_tog;
                    end
                    last_tog = cyc;
                end
                prev = spi_clk;
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    initial begin : main
        int   cyc;
        logic saw_rv;
        rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; cs_sel = 3'd0;
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_spi_clk", spi_clk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_cs_n", spi_cs_n, 5'h1f);
        rst = 1'b0;
        @(negedge clk);

        // Mode 0, div 0, loopback
        loop_en = 1'b1;
        xfer(8'hA5, 3'd0, 1'b0, 1'b0, 8'd0);
        chk("m0_rv_cycle", rv_cyc, 19);
        chk("m0_rx_data", rv_data, 8'hA5);
        chk("m0_cs_first", cs_first, 1);
        chk("m0_cs_last", cs_last, 18);
        chk("m0_other_cs", other_low, 0);
        chk("m0_rises", rises, 8);
        chk("m0_phase_min", imin, 1);
        chk("m0_phase_max", imax, 1);
        chk("m0_cs_at_rv", rv_cs, 5'h1f);
        chk("m0_ready_at_rv", rv_ready, 1);
        chk("m0_busy_at_rv", rv_busy, 0);
        @(negedge clk);
        chk("m0_rv_pulse", rx_valid, 0);
        chk("m0_rx_hold", rx_data, 8'hA5);

        // Mode 3, div 3, slave returns 0x3C
        loop_en = 1'b0; s_word = 8'h3C;
        xfer(8'hC3, 3'd1, 1'b1, 1'b1, 8'd3);
        chk("m3_rv_cycle", rv_cyc, 73);
        chk("m3_rx_data", rv_data, 8'h3C);
        chk("m3_slave_rx", s_rx, 8'hC3);
        chk("m3_cs_first", cs_first, 1);
        chk("m3_cs_last", cs_last, 72);
        chk("m3_toggles", tog, 16);
        chk("m3_phase_min", imin, 4);
        chk("m3_phase_max", imax, 4);
        @(negedge clk);
        chk("m3_sclk_idle", spi_clk, 1);

        // Mode 1, div 1
        s_word = 8'h6E;
        xfer(8'h81, 3'd3, 1'b0, 1'b1, 8'd1);
        chk("m1_rv_cycle", rv_cyc, 37);
        chk("m1_rx_data", rv_data, 8'h6E);
        chk("m1_slave_rx", s_rx, 8'h81);
        @(negedge clk);

        // Mode 2, div 0
        s_word = 8'hB7;
        xfer(8'h81, 3'd4, 1'b1, 1'b0, 8'd0);
        chk("m2_rv_cycle", rv_cyc, 19);
        chk("m2_rx_data", rv_data, 8'hB7);
        chk("m2_slave_rx", s_rx, 8'h81);
        @(negedge clk);

        // Chip-select decode: line 2 only, then out-of-range 6
        loop_en = 1'b1;
        xfer(8'h5C, 3'd2, 1'b0, 1'b0, 8'd0);
        chk("cs2_first", cs_first, 1);
        chk("cs2_last", cs_last, 18);
        chk("cs2_others", other_low, 0);
        chk("cs2_rx_data", rv_data, 8'h5C);
        @(negedge clk);
        xfer(8'h99, 3'd6, 1'b0, 1'b0, 8'd1);
        chk("cs6_none_low", other_low, 0);
        chk("cs6_rv_cycle", rv_cyc, 37);
        chk("cs6_rx_data", rv_data, 8'h99);
        @(negedge clk);

        // Back-to-back with tx_valid held high
        tx_data = 8'h11; cs_sel = 3'd0; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0;
        tx_valid = 1'b1;
        @(negedge clk);
        chk("b2b_busy_after_accept", tx_ready, 0);
        tx_data = 8'h22;
        cyc = 1;
        while (!rx_valid && cyc < 100) begin @(negedge clk); cyc++; end
        chk("b2b_first_rv_cycle", cyc, 19);
        chk("b2b_first_rx", rx_data, 8'h11);
        chk("b2b_ready_on_rv", tx_ready, 1);
        @(negedge clk);
        chk("b2b_second_accepted", busy, 1);
        tx_valid = 1'b0; cpol = 1'b1; cpha = 1'b1; clk_div = 8'd7; tx_data = 8'hEE;
        cyc = 1;
        while (!rx_valid && cyc < 200) begin @(negedge clk); cyc++; end
        chk("b2b_second_rv_cycle", cyc, 19);
        chk("b2b_second_rx", rx_data, 8'h22);
        @(negedge clk);

        // Reset during SHIFT aborts the transfer
        tx_data = 8'hF0; cs_sel = 3'd0; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("rstmid_in_shift", spi_cs_n, 5'h1e);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_cs_n", spi_cs_n, 5'h1f);
        chk("rstmid_spi_clk", spi_clk, 0);
        chk("rstmid_tx_ready", tx_ready, 1);
        chk("rstmid_rx_valid", rx_valid, 0);
        chk("rstmid_rx_data", rx_data, 0);
        rst = 1'b0;
        saw_rv = 1'b0;
        repeat (25) begin @(negedge clk); if (rx_valid) saw_rv = 1'b1; end
        chk("rstmid_no_rv", saw_rv, 0);
        xfer(8'h5A, 3'd0, 1'b0, 1'b0, 8'd0);
        chk("post_rst_rv_cycle", rv_cyc, 19);
        chk("post_rst_rx", rv_data, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
Parametrised SPI master with a valid/ready byte-stream interface, and the next generation of the team's fixed-mode SPI master.
- Supports all four SPI modes (CPOL/CPHA), selected per transfer.
- Runtime SCLK divider.
- NUM_CS one-hot chip selects.
- Sits between a register/DMA front end and off-chip SPI peripherals.
- One transfer is one DATA_WIDTH word, MSB first.

Parameters:
DATA_WIDTH, 8, bits per transfer word (2..32)
NUM_CS, 4, number of chip-select outputs (1..16)
DIV_WIDTH, 8, width of the clk_div input
CS_SEL_W, $clog2(NUM_CS) (min 1), width of cs_sel (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tx_data  in  DATA_WIDTH  word to send
tx_valid  in  1  request; held with all request fields until tx_ready
tx_ready  out  1  master idle, accepts a request
cs_sel  in  CS_SEL_W  target chip select, sampled at accept
cpol  in  1  clock polarity, sampled at accept
cpha  in  1  clock phase, sampled at accept
clk_div  in  DIV_WIDTH  half-period minus one, sampled at accept
rx_data  out  DATA_WIDTH  received word
rx_valid  out  1  one-cycle pulse, rx_data valid
busy  out  1  transfer in progress
spi_clk  out  1  SPI clock
spi_mosi  out  1  serial data out
spi_miso  in  1  serial data in
spi_cs_n  out  NUM_CS  active-low chip selects

Behaviour:
- Reset (rst high at a clk edge) values: tx_ready=1, rx_valid=0, busy=0, rx_data=0, spi_clk=0, spi_mosi=0, spi_cs_n=all ones, state=IDLE.
- Reset mid-transfer aborts immediately. No rx_valid is produced. CS deasserts on the same edge.
- Accept occurs on the cycle where tx_valid && tx_ready. At accept, tx_data, cs_sel, cpol, cpha and clk_div are latched. tx_ready is 0 from the next cycle.
- tx_valid while busy is ignored. No queueing.
- Half-period H = clk_div+1 clk cycles. clk_div=0 gives H=1, i.e. SCLK = clk/2.
- States:
  - IDLE: spi_clk = latched cpol (0 after reset); spi_cs_n all high; tx_ready=1.
  - SETUP: H cycles. spi_cs_n[cs_sel] low. Drives MSB on spi_mosi if cpha=0.
  - SHIFT: 2*DATA_WIDTH half-periods. spi_clk toggles at the end of each half-period.
  - HOLD: H cycles. spi_clk at idle level, CS still low.
  - Then back to IDLE.
- Edge roles:
  - Leading edge = first toggle away from cpol level; trailing edge = return.
  - cpha=0: sample spi_miso on leading edge; shift out next bit on trailing edge. The last trailing edge does not change spi_mosi.
  - cpha=1: drive next bit on leading edge, starting with the MSB on the first leading edge; sample on trailing edge.
- Timing, with accept on cycle 0:
  - spi_cs_n selected low on cycles 1..(2*DATA_WIDTH+2)*H.
  - On cycle (2*DATA_WIDTH+2)*H+1: CS deasserts, rx_valid=1 for exactly one cycle, rx_data updates, tx_ready=1, busy=0.
  - A new accept is possible on that same cycle.
- Out-of-range cs_sel (>= NUM_CS): the transfer runs with full timing and produces rx_valid, but no CS is asserted.
- busy equals !tx_ready.
- rx_data holds its value until the next completed transfer.
- Changes to the cpol/cpha/clk_div inputs during a transfer have no effect.
- Divider counter is DIV_WIDTH bits and reloads to the latched clk_div on every half-period boundary.
- bit counter is $clog2(DATA_WIDTH)+1 bits.

Decomposition:
- Package spi_pkg contains:
  - state enum (IDLE, SETUP, SHIFT, HOLD);
  - mode constants SPI_MODE0..3 as {cpol,cpha};
  - CS width function.
- Sub-module spi_clk_gen:
  - owns the divider;
  - emits one-cycle half_tick strobes and a lead/trail flag;
  - enabled only in SETUP/SHIFT/HOLD.
- The shift/FSM logic stays in the top.

Test Plan:
- Mode 0, DATA_WIDTH=8, clk_div=0, MOSI looped to MISO, tx 0xA5 -> rx_data=0xA5, rx_valid on cycle 19, 8 rising SCLK edges, CS[0] low on cycles 1..18.
- Mode 3, clk_div=3, slave model returns 0x3C while checking MOSI=0xC3 -> rx_data=0x3C, SCLK idles high, each SCLK phase lasts 4 clk, rx_valid on cycle 73.
- Modes 1 and 2 with a slave model, tx 0x81 -> correct sample edge per mode, rx_data matches slave word.
- cs_sel=2 with NUM_CS=4 -> only spi_cs_n[2] low; cs_sel=5 with NUM_CS=4 (CS_SEL_W=2 prevents this, so use NUM_CS=5 and cs_sel=6 on a width-3 bus) -> no CS asserted, rx_valid still pulses.
- tx_valid held high with words 0x11, 0x22 -> second accept on the rx_valid cycle of the first; inputs changed mid-transfer are ignored.
- rst asserted at SHIFT bit 3 -> next cycle: all CS high, spi_clk=0, tx_ready=1, no rx_valid; a subsequent transfer completes correctly.
